pio_host_bridge: RTL and testbench
==================================

// Module: pio_host_bridge
// PURPOSE
// Host-side initiator for the PIO block's command interface. Accepts a byte stream (e.g. from a UART
// receiver), assembles 6-byte command frames, and issues them as one-cycle action strobes with
// mindex/index/din. For action 3 (pull), captures the PIO dout word and returns it as 4 response bytes.
// Sits between the host serial link and the PIO top level.
// PARAMETERS
// TIMEOUT  100000  inter-byte gap limit in clk cycles inside a partial frame; 0 disables the timeout
// RD_LAT   2       cycles from a pull strobe to a valid PIO dout (>=1)
// PORTS
// clk        in   1   clock
// reset      in   1   reset, synchronous, active-high
// rx_data    in   8   host byte in
// rx_valid   in   1   rx_data valid
// rx_ready   out  1   bridge accepts a byte when rx_valid&rx_ready
// tx_data    out  8   response byte
// tx_valid   out  1   tx_data valid; held with tx_data stable until tx_ready
// tx_ready   in   1   sink accepts a byte when tx_valid&tx_ready
// action     out  4   PIO action code; nonzero for exactly one cycle per frame
// mindex     out  2   PIO machine index
// index      out  5   PIO instruction/pend index
// din        out  32  PIO data word
// dout       in   32  PIO read data
// busy       out  1   high in any state other than COLLECT, or when byte count is nonzero
// err        out  1   one-cycle pulse: frame timeout or illegal action code
// BEHAVIOUR
// - Reset: rx_ready=1, tx_valid=0, tx_data=0, action=0, mindex=0, index=0, din=0, busy=0, err=0;
//   state COLLECT, byte count 0, timeout counter 0. Reset mid-frame or mid-response discards all state.
// - Frame, in arrival order: B0[3:0]=action, B0[5:4]=mindex, B0[7:6] ignored; B1[4:0]=index, B1[7:5]
//   ignored; B2..B5 = din little-endian (B2=din[7:0]).
// - COLLECT: rx_ready=1; each accepted byte is stored and the count increments. The timeout counter
//   clears on each accepted byte and counts while count is 1..5. If it reaches TIMEOUT, the count
//   returns to 0, the partial frame is dropped, and err pulses for 1 cycle.
// - When byte 6 is accepted in cycle N: if B0[3:0] is in 11..15, pulse err in N+1, discard the frame,
//   and stay in COLLECT. Action 0 is a legal NOP: no strobe, frame consumed. Otherwise go to ISSUE.
// - ISSUE (cycle N+1): drive action/mindex/index/din for exactly this cycle; rx_ready=0. Next cycle
//   action=0 while mindex/index/din hold. If action==3, go to WAIT_RD; else go to COLLECT.
// - WAIT_RD: count RD_LAT cycles from the strobe cycle, latch dout into the response register, then go
//   to RESP.
// - RESP: send 4 bytes LSB-first; tx_valid=1; the byte index advances only on tx_valid&tx_ready.
//   After the 4th handshake, set tx_valid=0 and go to COLLECT. rx_ready=0 throughout; host bytes stall.
// - Response backpressure is unbounded; the timeout applies only in COLLECT.
// - rx_ready is registered and depends only on state; there is no combinational path from
//   rx_valid to rx_ready, or from tx_ready to tx_valid.
// - Minimum frame-to-frame throughput: 6 byte cycles + 1 issue cycle for non-pull frames.
// TESTING
// 1 Write instr: bytes 01,07,34,12,00,00 -> one cycle action=1, index=7, mindex=0, din=0x00001234;
//   then action=0 and rx_ready=1.
// 2 Pull: bytes 23,00,00,00,00,00 with dout=0xDEADBEEF at strobe+RD_LAT -> action=3, mindex=2 for
//   1 cycle; tx bytes EF,BE,AD,DE in order.
// 3 Backpressure: repeat 2 with tx_ready toggling every 3 cycles -> each byte is held stable until
//   its handshake; no loss or repeat; rx_ready stays 0 until the last handshake.
// 4 Timeout (TIMEOUT=16): send 2 bytes, idle 16 cycles -> err 1-cycle pulse, no strobe; next full
//   frame 06,00,0F,00,00,00 -> action=6, din=0x0F.
// 5 Illegal/NOP: frame 0C,... -> err pulse, no strobe; frame 00,... -> no strobe, no err.
// 6 Reset in RESP after 2 tx bytes -> all outputs at reset values the next cycle; subsequent frame is
//   decoded correctly.

Source files
------------

// File: rtl/pio_host_bridge.sv
// ----------------------------------------------------------------------------
// pio_host_bridge
//
// Host-side initiator for the PIO command interface. Host bytes are gathered
// into 6-byte frames and each legal frame is issued as a single-cycle action
// strobe carrying mindex/index/din. A pull (action 3) waits RD_LAT cycles
// from the strobe, captures dout, and streams it back as 4 bytes, LSB first.
//
// Frame layout (arrival order):
//   B0[3:0] action, B0[5:4] mindex, B0[7:6] unused
//   B1[4:0] index,  B1[7:5] unused
//   B2..B5  din, little-endian (B2 = din[7:0])
//
// Handshakes: a byte moves on a rising clk edge where valid and ready are
// both high. A source holds valid and its data stable until that edge, and
// neither valid nor ready ever depends combinationally on the other side.
// Here rx_ready and tx_valid are plain registers driven only by the FSM.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   rx_data/valid/ready   host byte stream in
//   tx_data/valid/ready   response byte stream out
//   action                PIO action code, nonzero for one cycle per frame
//   mindex, index, din    PIO command fields, held after the strobe
//   dout                  PIO read data, sampled RD_LAT cycles after a pull
//   busy                  high outside COLLECT or while a frame is partial
//   err                   one-cycle pulse on frame timeout or illegal action
//
// Parameters:
//   TIMEOUT  inter-byte gap limit (cycles) inside a partial frame; 0 = off
//   RD_LAT   cycles from pull strobe to valid dout (>= 1)
// ----------------------------------------------------------------------------
module pio_host_bridge #(
    parameter int TIMEOUT = 100000,
    parameter int RD_LAT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [3:0]  action,
    output logic [1:0]  mindex,
    output logic [4:0]  index,
    output logic [31:0] din,
    input  logic [31:0] dout,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    // Gap counter only needs to reach TIMEOUT-1: the drop happens on the
    // edge where it would have reached TIMEOUT.
    localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam int              RW       = $clog2(RD_LAT + 1);
    localparam logic [RW-1:0]   RD_LAST  = RW'(RD_LAT);

    logic [1:0]    state;
    logic [2:0]    byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [RW-1:0] rd_cnt;
    logic [3:0]    act_q;
    logic [1:0]    mi_q;
    logic [4:0]    idx_q;
    logic [23:0]   din_q;     // B2..B4 shifted in from the top
    logic [23:0]   resp_q;    // response bytes still to send after tx_data
    logic [1:0]    tx_idx;

    logic accept;
    assign accept = rx_valid & rx_ready;

    assign busy = (state != ST_COLLECT) || (byte_cnt != 3'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_COLLECT;
            byte_cnt <= 3'd0;
            tmo_cnt  <= '0;
            rd_cnt   <= '0;
            act_q    <= 4'd0;
            mi_q     <= 2'd0;
            idx_q    <= 5'd0;
            din_q    <= 24'd0;
            resp_q   <= 24'd0;
            tx_idx   <= 2'd0;
            rx_ready <= 1'b1;
            tx_valid <= 1'b0;
            tx_data  <= 8'd0;
            action   <= 4'd0;
            mindex   <= 2'd0;
            index    <= 5'd0;
            din      <= 32'd0;
            err      <= 1'b0;
        end else begin
            // Strobes and error pulses last one cycle unless re-asserted.
            err    <= 1'b0;
            action <= 4'd0;

            case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        tmo_cnt <= '0;
                        case (byte_cnt)
                            3'd0: begin
                                act_q <= rx_data[3:0];
                                mi_q  <= rx_data[5:4];
                            end
                            3'd1:             idx_q <= rx_data[4:0];
                            3'd2, 3'd3, 3'd4: din_q <= {rx_data, din_q[23:8]};
                            default: ;
                        endcase

                        if (byte_cnt == 3'd5) begin
                            // Last byte goes straight to din without a stop in din_q.
                            byte_cnt <= 3'd0;
                            if (act_q >= 4'd11) begin
                                err <= 1'b1;
                            end else if (act_q != 4'd0) begin
                                state    <= ST_ISSUE;
                                rx_ready <= 1'b0;
                                action   <= act_q;
                                mindex   <= mi_q;
                                index    <= idx_q;
                                din      <= {rx_data, din_q};
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else if ((TIMEOUT != 0) && (byte_cnt != 3'd0)) begin
                        if (tmo_cnt == TMO_LAST) begin
                            byte_cnt <= 3'd0;
                            tmo_cnt  <= '0;
                            err      <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end

                ST_ISSUE: begin
                    // action still holds the code issued this cycle.
                    if (action == 4'd3) begin
                        state  <= ST_WAIT_RD;
                        rd_cnt <= RW'(1);
                    end else begin
                        state    <= ST_COLLECT;
                        rx_ready <= 1'b1;
                    end
                end

                ST_WAIT_RD: begin
                    // rd_cnt = cycles elapsed since the strobe cycle.
                    if (rd_cnt == RD_LAST) begin
                        tx_data  <= dout[7:0];
                        resp_q   <= dout[31:8];
                        tx_idx   <= 2'd0;
                        tx_valid <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (tx_ready) begin
                        if (tx_idx == 2'd3) begin
                            tx_valid <= 1'b0;
                            state    <= ST_COLLECT;
                            rx_ready <= 1'b1;
                        end else begin
                            tx_idx  <= tx_idx + 2'd1;
                            tx_data <= resp_q[7:0];
                            resp_q  <= {8'd0, resp_q[23:8]};
                        end
                    end
                end

                default: begin
                    state    <= ST_COLLECT;
                    rx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pio_host_bridge.sv
// ----------------------------------------------------------------------------
// tb_pio_host_bridge
//
// Drives host frames into pio_host_bridge, models the PIO read port (dout
// valid exactly RD_LAT cycles after a pull strobe), and checks strobes,
// response bytes and error pulses against expectations derived from the
// frame bytes. Directed cases first, then randomized frames.
// ----------------------------------------------------------------------------
module tb_pio_host_bridge;

    localparam int TIMEOUT = 16;
    localparam int RD_LAT  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  action;
    logic [1:0]  mindex;
    logic [4:0]  index;
    logic [31:0] din;
    logic [31:0] dout;
    logic        busy;
    logic        err;

    // tx_ready source: 0 = random, 1 = toggle every 3 cycles, 2 = manual
    logic [1:0] tx_mode;
    logic       tx_ready_gen;
    logic       tx_ready_man;
    assign tx_ready = (tx_mode == 2'd2) ? tx_ready_man : tx_ready_gen;

    pio_host_bridge #(.TIMEOUT(TIMEOUT), .RD_LAT(RD_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .action   (action),
        .mindex   (mindex),
        .index    (index),
        .din      (din),
        .dout     (dout),
        .busy     (busy),
        .err      (err)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [42:0] exp_strobe_q[$];   // {action, mindex, index, din}
    logic [7:0]  exp_q[$];          // response bytes in send order
    logic [31:0] dout_q[$];         // values the PIO model returns per pull
    int          exp_err = 0;
    logic [31:0] pull_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what one complete 6-byte frame must produce.
    function automatic void expect_frame(input logic [47:0] f);
        logic [3:0] code;
        code = f[3:0];
        if (code >= 4'd11) begin
            exp_err++;
        end else if (code != 4'd0) begin
            exp_strobe_q.push_back({code, f[5:4], f[12:8], f[47:16]});
            if (code == 4'd3) begin
                dout_q.push_back(pull_val);
                for (int k = 0; k < 4; k++) exp_q.push_back(pull_val[8*k +: 8]);
            end
        end
    endfunction

    // ---------------- tx_ready generator ----------------
    initial begin : tx_ready_proc
        int tgl;
        tgl = 0;
        tx_ready_gen = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tx_mode == 2'd1) begin
                tgl++;
                if (tgl == 3) begin
                    tgl = 0;
                    tx_ready_gen = ~tx_ready_gen;
                end
            end else begin
                tx_ready_gen = ($urandom_range(3, 0) != 0);
            end
        end
    end

    // ---------------- PIO read-port model ----------------
    // dout is garbage except during cycle strobe+RD_LAT.
    initial begin : pio_model
        logic [31:0] v;
        dout = 32'd0;
        forever begin
            @(negedge clk);
            if (!reset && action == 4'd3) begin
                if (dout_q.size() != 0) v = dout_q.pop_front();
                else v = $urandom;
                dout = $urandom;
                repeat (RD_LAT) @(posedge clk);
                #1 dout = v;
                @(posedge clk);
                #1 dout = $urandom;
            end else begin
                dout = $urandom;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic        prev_stall;
        logic [7:0]  prev_data;
        logic [42:0] e;
        logic [7:0]  eb;
        prev_stall = 1'b0;
        prev_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (action != 4'd0) begin
                    if (exp_strobe_q.size() == 0) begin
                        chk("strobe_unexpected", 64'(action), 64'd0);
                    end else begin
                        e = exp_strobe_q.pop_front();
                        chk("strobe", 64'({action, mindex, index, din}), 64'(e));
                    end
                    chk("rx_ready_in_issue", 64'(rx_ready), 64'd0);
                end
                if (err) begin
                    n_checks++;
                    if (exp_err == 0) begin
                        n_errors++;
                        $display("FAIL err_unexpected got 1 expected 0");
                    end else begin
                        exp_err--;
                    end
                end
                if (tx_valid) chk("rx_ready_in_resp", 64'(rx_ready), 64'd0);
                if (prev_stall) begin
                    chk("tx_hold_valid", 64'(tx_valid), 64'd1);
                    chk("tx_hold_data", 64'(tx_data), 64'(prev_data));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("tx_unexpected", 64'(tx_valid), 64'd0);
                    end else begin
                        eb = exp_q.pop_front();
                        chk("tx_byte", 64'(tx_data), 64'(eb));
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int budget;
        bit done;
        budget = 0;
        done   = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (rx_ready) begin
                done = 1'b1;
            end else begin
                budget++;
                if (budget > 3000) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_accept_timeout got rx_ready=0 expected 1 within 3000 cycles");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] f, input int lo, input int hi);
        for (int i = 0; i < 6; i++) begin
            send_byte(f[8*i +: 8]);
            if (i < 5) gap(int'($urandom_range(hi, lo)));
        end
        expect_frame(f);
    endtask

    task automatic send_partial(input logic [47:0] f, input int nbytes, input int idle);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(f[8*i +: 8]);
            if (i < nbytes - 1) gap(int'($urandom_range(3, 0)));
        end
        exp_err++;
        gap(idle);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((exp_strobe_q.size() != 0 || exp_q.size() != 0 || exp_err != 0 || busy)
               && budget < 5000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk("drain_strobes", 64'(exp_strobe_q.size()), 64'd0);
        chk("drain_tx", 64'(exp_q.size()), 64'd0);
        chk("drain_err", 64'(exp_err), 64'd0);
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_rx_ready"}, 64'(rx_ready), 64'd1);
        chk({p, "_tx_valid"}, 64'(tx_valid), 64'd0);
        chk({p, "_tx_data"},  64'(tx_data),  64'd0);
        chk({p, "_action"},   64'(action),   64'd0);
        chk({p, "_mindex"},   64'(mindex),   64'd0);
        chk({p, "_index"},    64'(index),    64'd0);
        chk({p, "_din"},      64'(din),      64'd0);
        chk({p, "_busy"},     64'(busy),     64'd0);
        chk({p, "_err"},      64'(err),      64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog got no finish expected finish before 60000 cycles");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int hs;
        int budget;
        reset        = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = 8'd0;
        tx_mode      = 2'd0;
        tx_ready_man = 1'b0;
        pull_val     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;
        gap(2);

        // 1: write instruction, then strobe drops and rx_ready returns
        send_frame(48'h0000_1234_0701, 0, 1);
        chk("t1_action", 64'(action), 64'd1);
        chk("t1_index", 64'(index), 64'd7);
        chk("t1_din", 64'(din), 64'h1234);
        gap(1);
        chk("t1_action_after", 64'(action), 64'd0);
        chk("t1_rx_ready_after", 64'(rx_ready), 64'd1);
        chk("t1_index_hold", 64'(index), 64'd7);
        chk("t1_din_hold", 64'(din), 64'h1234);
        wait_drain();

        // 2: pull with mindex 2
        tx_mode  = 2'd0;
        pull_val = 32'hDEAD_BEEF;
        send_frame(48'h0000_0000_0023, 0, 0);
        wait_drain();

        // 3: pull under toggling backpressure, next frame offered at once
        tx_mode  = 2'd1;
        pull_val = $urandom;
        send_frame({8'h00, 32'h0, 8'h00, 8'h33}, 0, 0);
        send_frame({32'h89AB_CDEF, 8'h1F, 8'h15}, 0, 0);
        wait_drain();
        tx_mode = 2'd0;

        // 4: partial frame timeout after TIMEOUT idle cycles, then a frame
        //    whose inter-byte gaps sit one cycle under the limit
        send_partial(48'h0000_0000_0306, 2, TIMEOUT);
        send_frame(48'h0000_000F_0006, TIMEOUT - 1, TIMEOUT - 1);
        wait_drain();

        // 5: illegal action and NOP
        send_frame({8'h00, 32'($urandom), 8'h0C}, 0, 2);
        send_frame({8'h00, 32'($urandom), 8'h00}, 0, 2);
        wait_drain();

        // 6: reset in the middle of a response
        tx_mode      = 2'd2;
        tx_ready_man = 1'b0;
        pull_val     = $urandom;
        send_frame(48'h0000_0000_0013, 0, 0);
        hs     = 0;
        budget = 0;
        while (hs < 2 && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
            if (tx_valid) begin
                tx_ready_man = 1'b1;
                @(posedge clk);
                #1;
                tx_ready_man = 1'b0;
                hs++;
            end
        end
        chk("t6_handshakes", 64'(hs), 64'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("t6");
        reset = 1'b0;
        exp_q.delete();
        tx_mode = 2'd0;
        send_frame({32'h0BAD_F00D, 8'h0A, 8'h25}, 0, 2);
        wait_drain();

        // randomized frames
        for (int n = 0; n < 40; n++) begin
            logic [63:0] rnd;
            logic [47:0] f;
            int          r;
            rnd = {$urandom, $urandom};
            f   = rnd[47:0];
            r   = int'($urandom_range(9, 0));
            if (r == 0) begin
                send_partial(f, int'($urandom_range(5, 1)), TIMEOUT + 4);
            end else begin
                if (r <= 3) f[3:0] = 4'd3;
                pull_val = $urandom;
                send_frame(f, 0, 3);
                gap(int'($urandom_range(4, 0)));
            end
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
